// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the 0-9999 control/count stage
package counter_pkg;
  localparam int COUNT_W = 14;
  localparam int DEF_MAX_COUNT = 9999;
  typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2} state_t;
endpackage

// File: rtl/counter_10000_ctrl_if.sv
// counter_10000_ctrl_if: button pulses in, count/status out
interface counter_10000_ctrl_if;
  logic i_run_stop;
  logic i_clear;
  logic i_mode;
  logic [counter_pkg::COUNT_W-1:0] o_count;
  logic o_run;
  logic o_dir;
  logic o_tick;
  modport master (output i_run_stop, i_clear, i_mode, input o_count, o_run, o_dir, o_tick);
  modport slave (input i_run_stop, i_clear, i_mode, output o_count, o_run, o_dir, o_tick);
endinterface

// File: rtl/counter_tick_gen.sv
// counter_tick_gen: divides clk by TICK_DIV while enabled, registered one-cycle tick
module counter_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic o_tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] div_q, div_d;
  logic tick_q, tick_d;
  always_comb begin
    div_d = clr ? '0 : !en ? div_q : div_q == LAST ? '0 : div_q + 1'b1;
    tick_d = !clr && en && div_q == LAST;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tick_q <= tick_d;
    end
  end
  assign o_tick = tick_q;
endmodule

// File: rtl/counter_10000_ctrl.sv
// counter_10000_ctrl: run/stop/clear FSM plus wrapping 0..MAX_COUNT counter.
// Define COUNTER_DIR_EN to enable i_mode direction toggle and down-counting.
module counter_10000_ctrl
  import counter_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input logic clk,
  input logic reset,
  counter_10000_ctrl_if.slave bus
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam logic [COUNT_W-1:0] MAX = COUNT_W'(MAX_COUNT);
  state_t state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d, count_step;
  logic dir_q, dir_d, tick, tg_clr;
  // clear has priority over run_stop when both arrive in STOP
  always_comb begin
    state_d = state_q == CLEAR ? STOP :
              state_q == RUN   ? (bus.i_run_stop ? STOP : RUN) :
              bus.i_clear      ? CLEAR :
              bus.i_run_stop   ? RUN : STOP;
    tg_clr = state_q == CLEAR || (state_q != RUN && state_d == RUN);
`ifdef COUNTER_DIR_EN
    dir_d = dir_q ^ bus.i_mode;
    count_step = dir_q ? (count_q == '0 ? MAX : count_q - 1'b1)
                       : (count_q == MAX ? '0 : count_q + 1'b1);
`else
    dir_d = 1'b0;
    count_step = count_q == MAX ? '0 : count_q + 1'b1;
`endif
    count_d = state_q == CLEAR ? '0 : tick ? count_step : count_q;
  end
`ifndef COUNTER_DIR_EN
  logic unused_mode;
  assign unused_mode = bus.i_mode;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STOP;
      count_q <= '0;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q <= dir_d;
    end
  end
  counter_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .en(state_q == RUN),
    .clr(tg_clr),
    .o_tick(tick)
  );
  assign bus.o_count = count_q;
  assign bus.o_run = state_q == RUN;
  assign bus.o_dir = dir_q;
  assign bus.o_tick = tick;
endmodule

// File: tb/tb_counter_10000_ctrl.sv
// tb_counter_10000_ctrl: directed vector table plus multi-cycle sequences, TICK_DIV=4
module tb_counter_10000_ctrl;
  import counter_pkg::*;
  typedef struct {
    logic rs, cl, md;
    int cnt;
    logic run, tick;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  vec_t tbl[$];
  counter_10000_ctrl_if bus ();
  counter_10000_ctrl #(.CLK_FREQ(40), .TICK_HZ(10), .MAX_COUNT(9999)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rs, cl, md, input int cnt, input logic run, tick);
    tbl.push_back('{rs, cl, md, cnt, run, tick});
  endtask

  task automatic step(input logic rs, cl, md);
    @(negedge clk);
    bus.i_run_stop = rs;
    bus.i_clear = cl;
    bus.i_mode = md;
    @(posedge clk);
    #1;
    bus.i_run_stop = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_mode = 1'b0;
  endtask

  task automatic wait_count(input string name, input int exp, input int bound);
    for (int i = 0; i < bound && int'(bus.o_count) != exp; i++) step(0, 0, 0);
    chk(name, int'(bus.o_count), exp);
  endtask

  task automatic wait_change(input string name, input int exp);
    int prev;
    prev = int'(bus.o_count);
    for (int i = 0; i < 6 && int'(bus.o_count) == prev; i++) step(0, 0, 0);
    chk(name, int'(bus.o_count), exp);
  endtask

  initial begin
    int c, ticks;
    int exp_seq[4];
    bus.i_run_stop = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_mode = 1'b0;
    add(1, 0, 0, 0, 1, 0);
    repeat (3) add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) add(0, 0, 0, k, 1, 0);
      add(0, 0, 0, k, 1, 1);
    end
    add(0, 1, 0, 5, 1, 0);
    add(1, 0, 0, 5, 0, 0);
    add(0, 0, 0, 5, 0, 0);
    add(0, 1, 0, 5, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    #12;
    chk("reset_count", int'(bus.o_count), 0);
    chk("reset_run", int'(bus.o_run), 0);
    chk("reset_tick", int'(bus.o_tick), 0);
    chk("reset_dir", int'(bus.o_dir), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].cl, tbl[i].md);
      chk($sformatf("vec%0d_count", i), int'(bus.o_count), tbl[i].cnt);
      chk($sformatf("vec%0d_run", i), int'(bus.o_run), int'(tbl[i].run));
      chk($sformatf("vec%0d_tick", i), int'(bus.o_tick), int'(tbl[i].tick));
    end

    // run_stop and clear together from STOP with count 7
    step(1, 0, 0);
    wait_count("reach7", 7, 40);
    step(1, 0, 0);
    chk("stop7_count", int'(bus.o_count), 7);
    chk("stop7_run", int'(bus.o_run), 0);
    step(1, 1, 0);
    chk("both_state", int'(dut.state_q), int'(CLEAR));
    chk("both_run", int'(bus.o_run), 0);
    step(0, 0, 0);
    chk("both_count", int'(bus.o_count), 0);
    chk("both_state2", int'(dut.state_q), int'(STOP));
    chk("both_run2", int'(bus.o_run), 0);

    // stop in the cycle a tick is registered: that tick still counts
    step(1, 0, 0);
    for (int i = 0; i < 8 && bus.o_tick !== 1'b1; i++) step(0, 0, 0);
    chk("inflight_tick", int'(bus.o_tick), 1);
    c = int'(bus.o_count);
    step(1, 0, 0);
    chk("inflight_count", int'(bus.o_count), c + 1);
    chk("inflight_run", int'(bus.o_run), 0);
    repeat (8) step(0, 0, 0);
    chk("inflight_hold", int'(bus.o_count), c + 1);

    // asynchronous reset mid-RUN at 42
    step(0, 1, 0);
    step(0, 0, 0);
    chk("clr_again", int'(bus.o_count), 0);
    step(1, 0, 0);
    wait_count("reach42", 42, 200);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", int'(bus.o_count), 0);
    chk("arst_run", int'(bus.o_run), 0);
    chk("arst_tick", int'(bus.o_tick), 0);
    @(negedge clk);
    reset = 1'b0;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      if (bus.o_tick) ticks++;
    end
    chk("post_rst_ticks", ticks, 0);
    chk("post_rst_run", int'(bus.o_run), 0);

    // up wrap 9999 -> 0
    step(1, 0, 0);
    wait_count("reach9999", 9999, 40100);
    wait_change("wrap_up", 0);

    // direction toggle at 3
    wait_count("reach3", 3, 20);
    step(0, 0, 1);
`ifdef COUNTER_DIR_EN
    chk("mode_dir", int'(bus.o_dir), 1);
    exp_seq = '{2, 1, 0, 9999};
`else
    chk("mode_dir", int'(bus.o_dir), 0);
    exp_seq = '{4, 5, 6, 7};
`endif
    for (int i = 0; i < 4; i++) wait_change($sformatf("dir_step%0d", i), exp_seq[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_10000_ctrl.md
# counter_10000_ctrl

Control and count stage fed by the debounced single-cycle button pulses of the 0–9999 counter design. Runs a three-state run/stop/clear FSM, generates the count tick from the system clock, and maintains a 4-digit decimal count (0–9999) with wrap-around. Its count output feeds the FND/display stage downstream.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- TICK_HZ, 10, count rate in Hz; TICK_DIV = CLK_FREQ / TICK_HZ, with TICK_DIV ≥ 2
- MAX_COUNT, 9999, count wraps after this value
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- i_run_stop  input  1  one-cycle pulse; toggles run/stop
- i_clear  input  1  one-cycle pulse; clears count when stopped
- i_mode  input  1  one-cycle pulse; toggles count direction (only with the macro)
- o_count  output  14  current count, 0..MAX_COUNT
- o_run  output  1  high in RUN state
- o_dir  output  1  0 = up, 1 = down
- o_tick  output  1  one-cycle pulse per count step

## Operation
- FSM states: STOP (reset state), RUN, CLEAR.
- STOP:
  - i_clear → CLEAR.
  - Otherwise, i_run_stop → RUN.
  - If both pulses arrive in the same cycle, clear wins and run_stop is dropped.
- RUN:
  - i_run_stop → STOP.
  - i_clear is ignored.
- CLEAR: lasts exactly one cycle. o_count ← 0 and the divider ← 0, then unconditional → STOP.
- Divider (tick_gen):
  - Counts 0..TICK_DIV-1 only while in RUN. It holds its value in STOP and is zeroed on RUN entry.
  - On the edge where the divider equals TICK_DIV-1: divider ← 0 and o_tick ← 1 for one cycle.
- Count update, on the edge after o_tick = 1 (i.e. the edge where o_tick is sampled high):
  - up: MAX_COUNT → 0, else +1.
  - down: 0 → MAX_COUNT, else −1.
- A tick that is already registered when RUN→STOP occurs still updates the count once.
- Arithmetic is 14-bit unsigned. o_count never exceeds MAX_COUNT.
- Direction: i_mode toggles o_dir in any state and takes effect from the next count update.
- Reset values: state STOP, o_count 0, o_run 0, o_dir 0, o_tick 0, divider 0.
- Reset asserted mid-RUN returns to the reset values immediately (asynchronous).

## Timing
- o_run rises one cycle after the i_run_stop pulse is sampled in STOP.
- First o_tick after RUN entry: TICK_DIV cycles after the state becomes RUN.
- o_count changes 1 cycle after o_tick, then every TICK_DIV cycles after that.
- Clear: o_count reads 0 two cycles after the i_clear pulse (STOP→CLEAR→STOP).
- All outputs are registered. There is no combinational path from the inputs to the outputs.
- Inputs are synchronous to clk and at most one cycle wide. Back-to-back pulses are each honoured.

## Configuration
- COUNTER_DIR_EN defined:
  - i_mode toggles o_dir.
  - Down-count logic with 0→MAX_COUNT wrap is present.
- COUNTER_DIR_EN undefined:
  - i_mode is ignored and o_dir is tied to 0.
  - Up-count only; no down-count logic is synthesized.

## Structure
- Package counter_pkg holds:
  - state encoding typedef: STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2
  - COUNT_W = 14
  - the default MAX_COUNT
- One sub-module: counter_tick_gen.
  - Parameters: TICK_DIV.
  - Inputs: clk, reset, en, clr.
  - Output: o_tick.
  - Implements the divider and the tick register. The FSM and counter stay in the top module.

## Test plan
Use CLK_FREQ=40, TICK_HZ=10 (TICK_DIV=4) in simulation.
- Reset, then one i_run_stop pulse → o_run=1 next cycle; first o_tick 4 cycles later; o_count=1, 2, 3 at 4-cycle spacing.
- Preload by running to 9999 (up), let one more tick occur → o_count=0. With the macro, in the down direction at 0 → 9999.
- Run to 5, pulse i_run_stop, then i_clear while in RUN → count holds at 5 (plus at most one in-flight tick). After stopping, pulse i_clear → o_count=0 two cycles later; o_run stays 0.
- i_run_stop and i_clear in the same cycle from STOP with count 7 → state CLEAR then STOP, o_count=0, o_run=0.
- Macro defined: at count 3, pulse i_mode → o_dir=1; next ticks give 2, 1, 0, 9999. Macro undefined: i_mode pulse → o_dir stays 0 and counting continues up.
- Assert reset mid-RUN at count 42 → o_count=0, o_run=0, o_tick=0 immediately; after release no tick occurs until a new i_run_stop pulse.
